// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit queue.
package uart_pkg;

    localparam int DEF_CLK_FREQ = 1000000;
    localparam int DEF_BAUD     = 9600;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte-wide circular FIFO with registered count/full/empty flags.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [7:0]               i_data,
    output logic [7:0]               o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;

    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;

    assign w_pop  = i_pop & ~r_empty;
    assign w_push = i_push & (~r_full | w_pop);

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter via a newd/donetx handshake.
// Optional sticky overflow flag: define UART_TXQ_OVF_STICKY_EN.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD,
    parameter int DEPTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [7:0]              wr_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [7:0]              dintx,
    output logic                    newd,
    input  logic                    donetx,
    output logic                    busy
`ifdef UART_TXQ_OVF_STICKY_EN
    ,
    output logic                    ovf
`endif
);

    localparam int HOLD = CLK_FREQ / BAUD;
    localparam int HW   = $clog2(HOLD + 1);

    tx_state_e     r_state;
    logic [HW-1:0] r_hold;
    logic          r_newd;
    logic [7:0]    r_dintx;
    logic          r_done_q;

    tx_state_e     w_state_nxt;
    logic [HW-1:0] w_hold_nxt;
    logic          w_newd_nxt;
    logic [7:0]    w_dintx_nxt;
    logic          w_pop;
    logic          w_done_rise;
    logic [7:0]    w_fifo_data;

    uart_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (wr_en),
        .i_pop   (w_pop),
        .i_data  (wr_data),
        .o_data  (w_fifo_data),
        .o_full  (full),
        .o_empty (empty),
        .o_count (count)
    );

    assign w_done_rise = donetx & ~r_done_q;

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_newd_nxt  = r_newd;
        w_dintx_nxt = r_dintx;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!empty) begin
                    w_pop       = 1'b1;
                    w_dintx_nxt = w_fifo_data;
                    w_newd_nxt  = 1'b1;
                    w_hold_nxt  = HW'(HOLD - 1);
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                if (r_hold == '0) begin
                    w_newd_nxt  = 1'b0;
                    w_state_nxt = WAIT;
                end else begin
                    w_hold_nxt = r_hold - HW'(1);
                end
            end
            WAIT: begin
                // Only a fresh edge counts; a level left over from the
                // previous byte must not retire the current one.
                if (w_done_rise) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_hold   <= '0;
            r_newd   <= 1'b0;
            r_dintx  <= 8'h00;
            r_done_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            r_newd   <= w_newd_nxt;
            r_dintx  <= w_dintx_nxt;
            r_done_q <= donetx;
        end
    end

`ifdef UART_TXQ_OVF_STICKY_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (wr_en && full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`endif

    assign dintx = r_dintx;
    assign newd  = r_newd;
    assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue with a behavioural transmitter.
module tb_uart_tx_queue;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic [7:0] dintx;
    logic       newd;
    logic       donetx;
    logic       busy;
`ifdef UART_TXQ_OVF_STICKY_EN
    logic       ovf;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    bit         stall = 1'b0;

    uart_tx_queue #(
        .CLK_FREQ (1000000),
        .BAUD     (9600),
        .DEPTH    (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .dintx   (dintx),
        .newd    (newd),
        .donetx  (donetx),
        .busy    (busy)
`ifdef UART_TXQ_OVF_STICKY_EN
        ,
        .ovf     (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every newd launch must match the scoreboard head
    // and hold newd for exactly 104 cycles.
    initial begin
        logic       prev;
        int         hi;
        logic [7:0] exp;
        prev = 1'b0;
        hi   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
                hi   = 0;
            end else begin
                if (newd && !prev) begin
                    hi = 1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_launch", {24'h0, dintx}, 32'hFFFF_FFFF);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("tx_byte", {24'h0, dintx}, {24'h0, exp});
                    end
                end else if (newd) begin
                    hi++;
                end
                if (!newd && prev) chk("newd_width", hi, 104);
                prev = newd;
            end
        end
    end

    // Transmitter model: completes a few cycles after newd drops.
    initial begin
        logic prev;
        int   tx_cnt;
        int   hold;
        prev   = 1'b0;
        tx_cnt = 0;
        hold   = 0;
        donetx = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev   = 1'b0;
                tx_cnt = 0;
                hold   = 0;
                donetx = 1'b0;
            end else begin
                if (prev && !newd) tx_cnt = 5;
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) donetx = 1'b0;
                end
                if (tx_cnt > 0 && !stall) begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin
                        donetx = 1'b1;
                        hold   = 2;
                    end
                end
                prev = newd;
            end
        end
    end

    task automatic push(input logic [7:0] b, input bit expect_tx);
        wr_en   = 1'b1;
        wr_data = b;
        if (expect_tx) exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int peak);
        bit ok;
        ok   = 1'b0;
        peak = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int'(count) > peak) peak = int'(count);
            if (!busy && empty) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_done", {31'h0, ok}, 32'h1);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        int  peak;
        bit  ok;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_empty", {31'h0, empty}, 1);
        chk("rst_full",  {31'h0, full},  0);
        chk("rst_count", {28'h0, count}, 0);
        chk("rst_newd",  {31'h0, newd},  0);
        chk("rst_busy",  {31'h0, busy},  0);
        chk("rst_dintx", {24'h0, dintx}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte, first-byte latency
        push(8'hA5, 1'b1);
        chk("lat1_newd",  {31'h0, newd},  0);
        chk("lat1_empty", {31'h0, empty}, 0);
        chk("lat1_count", {28'h0, count}, 1);
        @(negedge clk);
        chk("lat2_newd",  {31'h0, newd},  1);
        chk("lat2_dintx", {24'h0, dintx}, 32'hA5);
        chk("lat2_busy",  {31'h0, busy},  1);
        chk("lat2_count", {28'h0, count}, 0);
        wait_idle(400, peak);

        // Burst ordering
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        push(8'h33, 1'b1);
        push(8'h44, 1'b1);
        chk("burst_count", {28'h0, count}, 3);
        wait_idle(1200, peak);
        chk("burst_peak", peak, 3);

        // Fill while the transmitter is stalled in WAIT
        stall = 1'b1;
        push(8'h5A, 1'b1);
        @(negedge clk);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!newd) begin
                ok = 1'b1;
                break;
            end
        end
        chk("stall_launch_end", {31'h0, ok}, 1);
        chk("stall_busy", {31'h0, busy}, 1);
        for (int b = 0; b < 8; b++) push(8'(b), 1'b1);
        chk("fill_full",  {31'h0, full},  1);
        chk("fill_count", {28'h0, count}, 8);
`ifdef UART_TXQ_OVF_STICKY_EN
        chk("fill_ovf", {31'h0, ovf}, 0);
`endif

        // Push in the same cycle that IDLE pops from a full FIFO
        stall = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_idle", {31'h0, ok}, 1);
        push(8'h09, 1'b1);
        chk("simul_count", {28'h0, count}, 8);
        chk("simul_full",  {31'h0, full},  1);
        chk("simul_newd",  {31'h0, newd},  1);
`ifdef UART_TXQ_OVF_STICKY_EN
        chk("simul_ovf", {31'h0, ovf}, 0);
`endif

        // Push into full FIFO with no pop: dropped
        push(8'h0A, 1'b0);
        chk("drop_count", {28'h0, count}, 8);
        chk("drop_full",  {31'h0, full},  1);
`ifdef UART_TXQ_OVF_STICKY_EN
        chk("drop_ovf", {31'h0, ovf}, 1);
`endif
        wait_idle(2500, peak);

        // Reset during LAUNCH with three bytes queued
        push(8'hB1, 1'b1);
        push(8'hB2, 1'b0);
        push(8'hB3, 1'b0);
        push(8'hB4, 1'b0);
        repeat (8) @(negedge clk);
        chk("pre_rst_newd",  {31'h0, newd},  1);
        chk("pre_rst_count", {28'h0, count}, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_newd",  {31'h0, newd},  0);
        chk("mid_rst_empty", {31'h0, empty}, 1);
        chk("mid_rst_count", {28'h0, count}, 0);
        chk("mid_rst_busy",  {31'h0, busy},  0);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("post_rst_empty", {31'h0, empty}, 1);
        chk("post_rst_busy",  {31'h0, busy},  0);
        chk("post_rst_sb",    exp_q.size(),   0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
